// File: rtl/instruction_fetch_queue_pkg.sv
// Shared CPU constants and the fetch queue entry type.
//   XLEN / ILEN        : address and instruction widths
//   NOP_ENCODING       : canonical ADDI x0,x0,0 encoding
//   END_MARKER         : all-zero word used as end-of-program marker
//   PC_STEP            : sequential fetch increment
//   fetch_entry_t      : {pc, instr} record stored in the queue
package instruction_fetch_queue_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_ENCODING = 32'h0000_0013;
    localparam logic [ILEN-1:0] END_MARKER   = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP      = 64'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_end_marker(input logic [ILEN-1:0] instr);
        return instr == END_MARKER;
    endfunction
endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch queue bus bundle: redirect from EX, request/response to instruction
// memory, and the valid/ready handshake towards decode.
//   master : the fetch queue side
//   slave  : memory + decode + branch unit side
interface instruction_fetch_queue_if;
    import instruction_fetch_queue_pkg::*;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [ILEN-1:0] resp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic            out_nop;

    modport master (
        input  redirect, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
        output req_valid, req_addr, out_valid, out_pc, out_instr, out_nop
    );

    modport slave (
        output redirect, redirect_pc, req_ready, resp_valid, resp_data, out_ready,
        input  req_valid, req_addr, out_valid, out_pc, out_instr, out_nop
    );
endinterface

// File: rtl/instruction_fetch_queue_fifo.sv
// Synchronous FIFO with flush, registered storage and no write-to-read bypass.
//   clk, reset   : clock, synchronous active-high reset
//   flush_i      : empty the FIFO (push in the same cycle is discarded)
//   push_i/wdata_i, pop_i : write / read handshake
//   rdata_o      : head entry, zero while empty
//   valid_o      : FIFO not empty
//   count_o      : number of stored entries
module instruction_fetch_queue_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupled instruction fetch front end. Issues sequential word fetches to a
// variable-latency memory, buffers returned words with their PCs and hands
// them to decode. A redirect flushes the queue and drops stale responses.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of instruction_fetch_queue_if
// Parameters: DEPTH (queue entries = max in-flight, power of two >= 2),
//             RESET_PC (first fetch address).
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic            accept, resp_keep, pop;
    fetch_entry_t    head, push_entry;

    // Credit: every outstanding request owns a queue slot, so kept responses
    // always find room.
    assign credit_used   = {1'b0, inflight_q} + {1'b0, count};
    assign bus.req_valid = !reset && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
    assign bus.req_addr  = fetch_pc_q;
    assign accept        = bus.req_valid && bus.req_ready;
    assign resp_keep     = bus.resp_valid && !bus.redirect && (drop_q == '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign push_entry    = '{pc: resp_pc_q, instr: bus.resp_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (bus.redirect) begin
            // Everything still in flight is stale; a response arriving now
            // is discarded directly, so it is not counted in drop.
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            inflight_d = inflight_q - CW'(bus.resp_valid);
            drop_d     = inflight_q - CW'(bus.resp_valid);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
            inflight_d = inflight_q + CW'(accept) - CW'(bus.resp_valid);
            if (bus.resp_valid) begin
                if (drop_q != '0) drop_d    = drop_q - CW'(1);
                else              resp_pc_d = resp_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    instruction_fetch_queue_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (bus.redirect),
        .push_i  (resp_keep),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .valid_o (bus.out_valid),
        .count_o (count)
    );

    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign bus.out_nop   = bus.out_valid && is_end_marker(head.instr);
endmodule
